ei_axi4_rst_ctrl: RTL and testbench

Parametrised reset sequencer and watchdog for AXI4 VIP benches and subsystems. It drives a separate active-low `aresetn_o` for each of NUM_CH AXI channel/agent domains. Each reset pulse has a programmable start delay and width, so a run can reset individual interfaces in the middle of a transfer. A watchdog counter flags a stalled run and can optionally force a reset on every channel.

---
 rtl/ei_axi4_rst_ctrl.sv | 142 ++++++++++++++
 tb/tb_ei_axi4_rst_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ei_axi4_rst_ctrl.sv
// Reset sequencer and watchdog: drives per-channel active-low AXI resets with a
// programmable start delay and width, plus a watchdog that can force a reset on every channel.
module ei_axi4_rst_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int MIN_PULSE = 2,
  parameter int WD_RST    = 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [CNT_W-1:0]  delay_i,
  input  logic [CNT_W-1:0]  width_i,
  output logic              ack_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [NUM_CH-1:0] aresetn_o,
  input  logic              wd_en_i,
  input  logic              wd_kick_i,
  input  logic [CNT_W-1:0]  wd_limit_i,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ASSERT,
    RELEASE
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  width_lat, width_next;
  logic [NUM_CH-1:0] mask, mask_next;
  logic [CNT_W-1:0]  eff_width;
  logic [CNT_W-1:0]  wd_cnt;
  logic              pending;
  logic              accept;
  logic              take_forced;
  logic              wd_hit;
  logic              wd_inc;

  // A pending watchdog reset takes the IDLE slot ahead of any start request.
  always_comb begin
    eff_width   = (width_i > MIN_W) ? width_i : MIN_W;
    take_forced = (state == IDLE) && pending;
    accept      = (state == IDLE) && !pending && start_i && (ch_mask_i != '0);
    state_next  = state;
    cnt_next    = cnt;
    mask_next   = mask;
    width_next  = width_lat;
    case (state)
      IDLE: begin
        if (take_forced) begin
          mask_next  = '1;
          width_next = MIN_W;
          cnt_next   = MIN_W;
          state_next = ASSERT;
        end else if (accept) begin
          mask_next  = ch_mask_i;
          width_next = eff_width;
          if (delay_i == '0) begin
            cnt_next   = eff_width;
            state_next = ASSERT;
          end else begin
            cnt_next   = delay_i;
            state_next = DELAY;
          end
        end
      end
      DELAY: begin
        if (cnt <= ONE) begin
          cnt_next   = width_lat;
          state_next = ASSERT;
        end else begin
          cnt_next = cnt - ONE;
        end
      end
      ASSERT: begin
        if (cnt <= ONE) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt - ONE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs trail the state register by one edge, so the reset pulse lands
  // one cycle after the FSM enters ASSERT and lasts exactly the latched width.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      cnt       <= '0;
      width_lat <= '0;
      mask      <= '0;
      ack_o     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      aresetn_o <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      width_lat <= width_next;
      mask      <= mask_next;
      ack_o     <= accept;
      busy_o    <= accept || take_forced || (state != IDLE);
      done_o    <= (state == RELEASE);
      aresetn_o <= (state == ASSERT) ? ~mask : '1;
    end
  end

  assign wd_hit = (wd_limit_i != '0) && (wd_cnt >= wd_limit_i) && !timeout_o;
  assign wd_inc = wd_en_i && (wd_limit_i != '0) && !timeout_o && (wd_cnt < wd_limit_i);

  // The count freezes at the limit, so an all-ones limit can never wrap.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (wd_kick_i) begin
        wd_cnt    <= '0;
        timeout_o <= 1'b0;
      end else begin
        if (wd_hit) timeout_o <= 1'b1;
        if (wd_inc) wd_cnt <= wd_cnt + ONE;
      end
      if ((WD_RST != 0) && wd_hit && !wd_kick_i) pending <= 1'b1;
      else if (take_forced) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ei_axi4_rst_ctrl.sv
// Directed bench for ei_axi4_rst_ctrl: each step drives inputs and checks the
// registered outputs 1 time unit after the rising edge against hand-computed values.
module tb_ei_axi4_rst_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start_i;
  logic [3:0]  ch_mask_i;
  logic [15:0] delay_i;
  logic [15:0] width_i;
  logic        ack_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  aresetn_o;
  logic        wd_en_i;
  logic        wd_kick_i;
  logic [15:0] wd_limit_i;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  ei_axi4_rst_ctrl #(
    .NUM_CH(4), .CNT_W(16), .MIN_PULSE(2), .WD_RST(1)
  ) dut (
    .aclk(aclk), .areset(areset), .start_i(start_i), .ch_mask_i(ch_mask_i),
    .delay_i(delay_i), .width_i(width_i), .ack_o(ack_o), .busy_o(busy_o),
    .done_o(done_o), .aresetn_o(aresetn_o), .wd_en_i(wd_en_i),
    .wd_kick_i(wd_kick_i), .wd_limit_i(wd_limit_i), .timeout_o(timeout_o)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic start, input logic [3:0] mask,
                                input logic [15:0] delay, input logic [15:0] width);
    start_i   = start;
    ch_mask_i = mask;
    delay_i   = delay;
    width_i   = width;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] rstn, input logic ack,
                           input logic busy, input logic done, input logic tmo);
    check_output({tag, ".aresetn"}, 32'(aresetn_o), 32'(rstn));
    check_output({tag, ".ack"},     32'(ack_o),     32'(ack));
    check_output({tag, ".busy"},    32'(busy_o),    32'(busy));
    check_output({tag, ".done"},    32'(done_o),    32'(done));
    check_output({tag, ".timeout"}, 32'(timeout_o), 32'(tmo));
  endtask

  initial begin
    areset     = 1'b1;
    wd_en_i    = 1'b0;
    wd_kick_i  = 1'b0;
    wd_limit_i = 16'd0;
    apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);

    // Block reset held for three edges, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("rst%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    areset = 1'b0;
    tick();
    check_all("rst_release", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Masked sequence D=3 W=5, with start_i retried while busy.
    $display("[TB] masked sequence");
    apply_stimulus(1'b1, 4'b0101, 16'd3, 16'd5);
    tick();
    check_all("mask_N", 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 2 || k == 3) apply_stimulus(1'b1, 4'b1111, 16'd0, 16'd0);
      else apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);
      tick();
      check_all($sformatf("mask_N+%0d", k), (k >= 4 && k <= 8) ? 4'b1010 : 4'b1111,
                1'b0, k < 10, k == 9, 1'b0);
    end

    // Zero width and delay fall back to a MIN_PULSE pulse starting at N+1.
    $display("[TB] minimum pulse");
    apply_stimulus(1'b1, 4'b1111, 16'd0, 16'd0);
    tick();
    check_all("minw_N", 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_all($sformatf("minw_N+%0d", k), (k <= 2) ? 4'b0000 : 4'b1111,
                1'b0, k < 4, k == 3, 1'b0);
    end

    // An empty mask is never accepted.
    apply_stimulus(1'b1, 4'b0000, 16'd1, 16'd4);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_all($sformatf("nomask%0d", k), 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);

    // Watchdog limit 10: timeout at edge 11, forced all-channel pulse at edges 13-14.
    $display("[TB] watchdog");
    wd_limit_i = 16'd10;
    wd_en_i    = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check_all($sformatf("wd_e%0d", e), (e == 13 || e == 14) ? 4'b0000 : 4'b1111,
                1'b0, e >= 12 && e <= 15, e == 15, e >= 11);
    end
    wd_en_i   = 1'b0;
    wd_kick_i = 1'b1;
    tick();
    check_output("wd_kick.timeout", 32'(timeout_o), 32'd0);
    wd_kick_i = 1'b0;
    tick();
    check_all("wd_after_kick", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout mid-sequence: sequence finishes, forced reset follows, colliding start dropped.
    $display("[TB] collision");
    wd_limit_i = 16'd4;
    wd_en_i    = 1'b1;
    apply_stimulus(1'b1, 4'b0011, 16'd2, 16'd3);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 7) apply_stimulus(1'b1, 4'b1111, 16'd0, 16'd0);
      else apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);
      check_all($sformatf("col_e%0d", e),
                (e >= 4 && e <= 6) ? 4'b1100 : ((e == 9 || e == 10) ? 4'b0000 : 4'b1111),
                e == 1, e <= 11, e == 7 || e == 11, e >= 5);
    end
    wd_en_i   = 1'b0;
    wd_kick_i = 1'b1;
    tick();
    wd_kick_i  = 1'b0;
    wd_limit_i = 16'd0;
    check_output("col_kick.timeout", 32'(timeout_o), 32'd0);

    // Abort during ASSERT, then a normal sequence after release.
    $display("[TB] abort");
    apply_stimulus(1'b1, 4'b1111, 16'd0, 16'd6);
    tick();
    apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);
    tick();
    check_all("abort_assert", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    areset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_all($sformatf("abort_rst%0d", k), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    areset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("abort_idle%0d", k), 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b1, 4'b1000, 16'd1, 16'd2);
    tick();
    check_all("resume_N", 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 16'd0, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_all($sformatf("resume_N+%0d", k), (k == 2 || k == 3) ? 4'b0111 : 4'b1111,
                1'b0, k < 5, k == 4, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
